// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_t : per-slot phase (blank dead time / lit)
//   seg_t        : segment byte {DP,G,F,E,D,C,B,A}, 1 = segment lit
package seg7_scan_ctrl_pkg;

   typedef logic [0:0] scan_state_t;
   localparam scan_state_t ST_BLANK = 1'b0;
   localparam scan_state_t ST_ON    = 1'b1;

   typedef logic [7:0] seg_t;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam int unsigned WR_ADDR_W = 3;
   localparam int unsigned BRIGHT_W  = 4;
   localparam int unsigned PWM_STEPS = 16;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side register interface of the scan controller.
//   wr_en/wr_addr/wr_data : shadow digit write
//   commit                : request shadow->active copy at frame end
//   bright                : 4-bit brightness
//   pending               : commit outstanding (driven by the controller)
interface seg7_scan_ctrl_if;
   import seg7_scan_ctrl_pkg::*;

   logic                 wr_en;
   logic [WR_ADDR_W-1:0] wr_addr;
   seg_t                 wr_data;
   logic                 commit;
   logic [BRIGHT_W-1:0]  bright;
   logic                 pending;

   modport master (output wr_en, wr_addr, wr_data, commit, bright, input pending);
   modport slave  (input wr_en, wr_addr, wr_data, commit, bright, output pending);

endinterface

// File: rtl/seg7_scan_ctrl_slot_timer.sv
// Slot sequencer: slot counter, digit index, blank/on phase and frame tick.
//   clk_sys, rst_sys_n : clock, async active-low reset
//   cnt                : position inside current slot, 0..SCAN_DIV-1
//   idx                : digit being scanned
//   state              : ST_BLANK while cnt < BLANK_CYC, else ST_ON
//   frame_tick         : high exactly while cnt is last and idx is last
module seg7_scan_ctrl_slot_timer
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SCAN_DIV   = 6250,
   parameter int unsigned BLANK_CYC  = 64,
   parameter int unsigned CNT_W      = $clog2(SCAN_DIV),
   parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic             clk_sys,
   input  logic             rst_sys_n,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] idx,
   output scan_state_t      state,
   output logic             frame_tick
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic             wrap;
   logic [CNT_W-1:0] cnt_next;
   logic [IDX_W-1:0] idx_next;
   scan_state_t      state_next;
   logic             tick_next;

   assign wrap = (cnt == CNT_LAST);

   // Next-state: phase changes when the counter enters the lit window or wraps.
   // frame_tick is decoded from next values so the registered pulse lines up
   // with the last counter position of the last digit.
   always_comb begin
      cnt_next   = wrap ? '0 : cnt + CNT_W'(1);
      idx_next   = idx;
      state_next = state;
      if (wrap) idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      case (state)
         ST_BLANK: if (cnt_next == CNT_BLANK) state_next = ST_ON;
         ST_ON:    if (wrap)                  state_next = ST_BLANK;
         default:                             state_next = ST_BLANK;
      endcase
      tick_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         cnt        <= '0;
         idx        <= '0;
         state      <= ST_BLANK;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         idx        <= idx_next;
         state      <= state_next;
         frame_tick <= tick_next;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with dead time,
// 4-bit PWM brightness and double-buffered digit data.
//   clk_sys, rst_sys_n : clock, async active-low reset
//   bus (slave)        : shadow writes, commit, brightness, pending flag
//   dig_en             : digit enables, polarity per ACTIVE_LOW
//   seg                : segment drives {DP,G..A}, polarity per ACTIVE_LOW
//   frame_tick         : 1-cycle pulse at end of the last digit slot
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SCAN_DIV   = 6250,
   parameter int unsigned BLANK_CYC  = 64,
   parameter int unsigned ACTIVE_LOW = 1
) (
   input  logic                  clk_sys,
   input  logic                  rst_sys_n,
   seg7_scan_ctrl_if.slave       bus,
   output logic [NUM_DIGITS-1:0] dig_en,
   output seg_t                  seg,
   output logic                  frame_tick
);

   localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
   localparam int unsigned ON_CYC = SCAN_DIV - BLANK_CYC;
   localparam int unsigned STEP   = ON_CYC / PWM_STEPS;
   localparam logic        POL    = (ACTIVE_LOW != 0);

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   scan_state_t         state;

   seg_t                shadow_q [NUM_DIGITS];
   seg_t                active_q [NUM_DIGITS];
   logic                pending_q;
   logic [BRIGHT_W-1:0] bright_q;

   logic                wr_hit_c;
   logic                copy_c;
   logic [CNT_W-1:0]    on_cnt;
   logic [CNT_W-1:0]    on_limit;
   logic                lit_c;
   logic [NUM_DIGITS-1:0] dig_on_c;
   seg_t                seg_on_c;

   seg7_scan_ctrl_slot_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .BLANK_CYC  (BLANK_CYC),
      .CNT_W      (CNT_W),
      .IDX_W      (IDX_W)
   ) u_timer (
      .clk_sys    (clk_sys),
      .rst_sys_n  (rst_sys_n),
      .cnt        (cnt),
      .idx        (idx),
      .state      (state),
      .frame_tick (frame_tick)
   );

   assign wr_hit_c = bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS);
   assign copy_c   = frame_tick && pending_q;
   assign on_cnt   = cnt - CNT_W'(BLANK_CYC);
   assign on_limit = CNT_W'(bright_q) * CNT_W'(STEP);
   assign bus.pending = pending_q;

   // Digit registers. The copy reads pre-edge shadow, so a write landing on the
   // copy cycle only reaches shadow. A commit on the copy cycle re-arms pending.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         shadow_q  <= '{default: '0};
         active_q  <= '{default: '0};
         pending_q <= 1'b0;
         bright_q  <= '0;
      end else begin
         if (wr_hit_c) shadow_q[IDX_W'(bus.wr_addr)] <= bus.wr_data;
         if (copy_c)   active_q <= shadow_q;
         pending_q <= bus.commit | (pending_q & ~copy_c);
         if (cnt == '0) bright_q <= bus.bright;
      end
   end

   // PWM gate: full brightness lights the whole window, otherwise the first
   // bright*STEP cycles of it.
   always_comb begin
      lit_c    = 1'b0;
      dig_on_c = '0;
      seg_on_c = '0;
      if (state == ST_ON) begin
         if (bright_q == '1) lit_c = 1'b1;
         else if ((bright_q != '0) && (on_cnt < on_limit)) lit_c = 1'b1;
      end
      if (lit_c) begin
         dig_on_c = NUM_DIGITS'(1) << idx;
         seg_on_c = active_q[idx];
      end
   end

   // Pin registers with polarity applied; reset drives every pin inactive.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         dig_en <= {NUM_DIGITS{POL}};
         seg    <= {8{POL}};
      end else begin
         dig_en <= dig_on_c ^ {NUM_DIGITS{POL}};
         seg    <= seg_on_c ^ {8{POL}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: an 8-digit instance (A) and a 6-digit
// instance (B), both SCAN_DIV=100, BLANK_CYC=4, ACTIVE_LOW=1.
module tb_seg7_scan_ctrl;
   import seg7_scan_ctrl_pkg::*;

   logic clk_sys = 1'b0;
   logic rst_sys_n;
   always #5 clk_sys = ~clk_sys;

   seg7_scan_ctrl_if bus_a ();
   seg7_scan_ctrl_if bus_b ();

   logic [7:0] dig_a;
   logic [5:0] dig_b;
   seg_t       seg_a, seg_b;
   logic       ft_a, ft_b;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(100), .BLANK_CYC(4), .ACTIVE_LOW(1)) dut_a (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus_a),
      .dig_en(dig_a), .seg(seg_a), .frame_tick(ft_a));

   seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(100), .BLANK_CYC(4), .ACTIVE_LOW(1)) dut_b (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus_b),
      .dig_en(dig_b), .seg(seg_b), .frame_tick(ft_b));

   // kind: 0 = pins, 1 = frame_tick, 2 = pending
   typedef struct {
      int unsigned cyc;
      int          dut;
      int          kind;
      logic [7:0]  dig;
      logic [7:0]  seg;
      logic        bitv;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned gcyc = 0;
   int unsigned base = 0;

   always @(posedge clk_sys) gcyc <= gcyc + 1;

   function automatic int unsigned at(int unsigned slot, int unsigned c);
      return base + slot * 100 + c + 1;
   endfunction

   task automatic exp_pins(int dut, int unsigned cyc, logic [7:0] dig, logic [7:0] sg, string name);
      exp_t e;
      e.cyc = cyc; e.dut = dut; e.kind = 0; e.dig = dig; e.seg = sg; e.bitv = 1'b0; e.name = name;
      sb.push_back(e);
   endtask

   task automatic exp_bit(int dut, int kind, int unsigned cyc, logic v, string name);
      exp_t e;
      e.cyc = cyc; e.dut = dut; e.kind = kind; e.dig = '0; e.seg = '0; e.bitv = v; e.name = name;
      sb.push_back(e);
   endtask

   // Returns #1 after the edge at which the DUT counter position equals p.
   task automatic wait_pos(int unsigned p);
      while (gcyc < base + p) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic write_a(logic [2:0] a, logic [7:0] d, logic cm);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d; bus_a.commit = cm;
      @(posedge clk_sys);
      #1;
      bus_a.wr_en = 1'b0; bus_a.commit = 1'b0;
   endtask

   // Monitor: compares every entry whose cycle has come; late entries are failures.
   always @(negedge clk_sys) begin
      int         i;
      exp_t       e;
      logic [7:0] ad, as;
      logic       af, ap;
      i = 0;
      while (i < sb.size()) begin
         e = sb[i];
         if (e.cyc > gcyc) begin
            i++;
         end else begin
            sb.delete(i);
            vectors++;
            if (e.dut == 0) begin
               ad = dig_a; as = seg_a; af = ft_a; ap = bus_a.pending;
            end else begin
               ad = {2'b00, dig_b}; as = seg_b; af = ft_b; ap = bus_b.pending;
            end
            if (e.cyc < gcyc) begin
               miscompares++;
               $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.cyc, gcyc);
            end else if (e.kind == 0 && (ad !== e.dig || as !== e.seg)) begin
               miscompares++;
               $display("FAIL %s: dig_en=%h seg=%h, required dig_en=%h seg=%h",
                        e.name, ad, as, e.dig, e.seg);
            end else if (e.kind == 1 && af !== e.bitv) begin
               miscompares++;
               $display("FAIL %s: frame_tick=%b, required %b", e.name, af, e.bitv);
            end else if (e.kind == 2 && ap !== e.bitv) begin
               miscompares++;
               $display("FAIL %s: pending=%b, required %b", e.name, ap, e.bitv);
            end
         end
      end
   end

   initial begin
      exp_t       e;
      logic [7:0] m;
      rst_sys_n = 1'b0;
      bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.commit = 1'b0; bus_a.bright = 4'd15;
      bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.commit = 1'b0; bus_b.bright = 4'd15;
      repeat (2) @(posedge clk_sys);
      #1;
      exp_pins(0, gcyc, 8'hFF, 8'hFF, "rst_pins_a");
      exp_bit (0, 1, gcyc, 1'b0, "rst_tick_a");
      exp_bit (0, 2, gcyc, 1'b0, "rst_pend_a");
      exp_pins(1, gcyc, 8'h3F, 8'hFF, "rst_pins_b");
      repeat (2) @(posedge clk_sys);
      #1;
      rst_sys_n = 1'b1;
      base = gcyc;

      // Reset release and first slots
      exp_pins(0, at(0, 0),  8'hFF, 8'hFF, "t1_blank0");
      exp_pins(0, at(0, 3),  8'hFF, 8'hFF, "t1_blank3");
      exp_pins(0, at(0, 4),  8'hFE, 8'hFF, "t1_on4");
      exp_pins(0, at(0, 99), 8'hFE, 8'hFF, "t1_on99");
      exp_pins(0, at(1, 0),  8'hFF, 8'hFF, "t1_slot1_blank");
      exp_pins(0, at(1, 4),  8'hFD, 8'hFF, "t1_slot1_on");
      // Write + commit becomes visible only after frame_tick
      exp_bit (0, 2, base + 11,  1'b1, "t2_pend_set");
      exp_pins(0, at(3, 4),  8'hF7, 8'hFF, "t2_no_early");
      exp_bit (0, 1, base + 798, 1'b0, "t2_tick_before");
      exp_bit (0, 1, base + 799, 1'b1, "t2_tick");
      exp_bit (0, 1, base + 800, 1'b0, "t2_tick_after");
      exp_bit (0, 2, base + 799, 1'b1, "t2_pend_at_tick");
      exp_bit (0, 2, base + 800, 1'b0, "t2_pend_clr");
      exp_pins(0, at(11, 3),  8'hFF, 8'hFF, "t2_d3_blank");
      exp_pins(0, at(11, 4),  8'hF7, 8'hC0, "t2_d3_on");
      exp_pins(0, at(11, 99), 8'hF7, 8'hC0, "t2_d3_end");
      // Out-of-range address on the 6-digit instance; addr0 as positive control
      exp_bit (1, 1, base + 598, 1'b0, "t6_b_tick_before");
      exp_bit (1, 1, base + 599, 1'b1, "t6_b_tick");
      exp_bit (1, 1, base + 600, 1'b0, "t6_b_tick_after");
      exp_bit (1, 2, base + 600, 1'b0, "t6_b_pend_clr");
      exp_bit (1, 1, base + 1199, 1'b1, "t6_b_tick2");
      for (int d = 0; d < 6; d++) begin
         m = 8'h3F & ~(8'h01 << d);
         exp_pins(1, at(6 + d, 4), m, (d == 0) ? 8'hFE : 8'hFF, $sformatf("t6_b_digit%0d", d));
      end
      // PWM brightness
      exp_pins(0, at(12, 3),  8'hFF, 8'hFF, "t3_b4_blank");
      exp_pins(0, at(12, 4),  8'hEF, 8'hFF, "t3_b4_first");
      exp_pins(0, at(12, 27), 8'hEF, 8'hFF, "t3_b4_last_on");
      exp_pins(0, at(12, 28), 8'hFF, 8'hFF, "t3_b4_first_off");
      exp_pins(0, at(12, 60), 8'hFF, 8'hFF, "t3_midslot_ignored");
      exp_pins(0, at(12, 99), 8'hFF, 8'hFF, "t3_b4_end");
      exp_pins(0, at(13, 60), 8'hDF, 8'hFF, "t3_new_slot");
      exp_pins(0, at(14, 4),  8'hFF, 8'hFF, "t3_dark4");
      exp_pins(0, at(14, 50), 8'hFF, 8'hFF, "t3_dark50");
      exp_pins(0, at(14, 99), 8'hFF, 8'hFF, "t3_dark99");
      // Commit and write on the copy cycle
      exp_bit (0, 2, base + 1501, 1'b1, "t4_pend_set");
      exp_bit (0, 1, base + 1599, 1'b1, "t4_tick");
      exp_bit (0, 2, base + 1600, 1'b1, "t4_pend_kept");
      exp_pins(0, at(17, 4),  8'hFD, 8'hF9, "t4_d1_copied");
      exp_pins(0, at(18, 4),  8'hFB, 8'hFF, "t4_write_excluded");
      exp_pins(0, at(19, 27), 8'hF7, 8'hC0, "t4_d3_pwm_on");
      exp_pins(0, at(19, 28), 8'hFF, 8'hFF, "t4_d3_pwm_off");
      exp_bit (0, 1, base + 2399, 1'b1, "t4_tick2");
      exp_bit (0, 2, base + 2399, 1'b1, "t4_pend_before_copy2");
      exp_bit (0, 2, base + 2400, 1'b0, "t4_pend_clr2");
      exp_pins(0, at(26, 4),  8'hFB, 8'hA4, "t4_second_copy");
      exp_pins(0, at(27, 4),  8'hF7, 8'hC0, "t4_d3_kept");
      exp_pins(0, at(29, 40), 8'hDF, 8'h92, "t4_d5_before_rst");

      wait_pos(10);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd3; bus_a.wr_data = 8'h3F; bus_a.commit = 1'b1;
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd7; bus_b.wr_data = 8'hFF; bus_b.commit = 1'b1;
      @(posedge clk_sys);
      #1;
      bus_a.wr_en = 1'b0; bus_a.commit = 1'b0;
      bus_b.wr_addr = 3'd0; bus_b.wr_data = 8'h01; bus_b.commit = 1'b0;
      @(posedge clk_sys);
      #1;
      bus_b.wr_en = 1'b0;

      wait_pos(1195); bus_a.bright = 4'd4;
      wait_pos(1250); bus_a.bright = 4'd15;
      wait_pos(1395); bus_a.bright = 4'd0;
      wait_pos(1495); bus_a.bright = 4'd15;
      wait_pos(1500); write_a(3'd1, 8'h06, 1'b1);
      wait_pos(1599); write_a(3'd2, 8'h5B, 1'b1);
      wait_pos(1895); bus_a.bright = 4'd4;
      wait_pos(1995); bus_a.bright = 4'd15;
      wait_pos(2000); write_a(3'd5, 8'h6D, 1'b0);

      // Asynchronous reset in the middle of slot 5
      wait_pos(2950);
      exp_pins(0, gcyc, 8'hFF, 8'hFF, "t5_async_pins");
      exp_bit (0, 2, gcyc, 1'b0, "t5_async_pend");
      exp_pins(1, gcyc, 8'h3F, 8'hFF, "t5_async_pins_b");
      rst_sys_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      rst_sys_n = 1'b1;
      base = gcyc;
      exp_pins(0, at(0, 3),  8'hFF, 8'hFF, "t5_restart_blank");
      exp_pins(0, at(0, 4),  8'hFE, 8'hFF, "t5_restart_d0");
      exp_pins(0, at(5, 4),  8'hDF, 8'hFF, "t5_active_cleared");
      exp_pins(0, at(11, 4), 8'hF7, 8'hFF, "t5_shadow_cleared");
      exp_bit (0, 1, base + 799,  1'b1, "t6_tick_f0");
      exp_bit (0, 1, base + 1598, 1'b0, "t6_tick_pre");
      exp_bit (0, 1, base + 1599, 1'b1, "t6_tick_f1");
      exp_bit (0, 1, base + 1600, 1'b0, "t6_tick_post");
      wait_pos(10);
      bus_a.commit = 1'b1;
      @(posedge clk_sys);
      #1;
      bus_a.commit = 1'b0;

      for (int k = 0; k < 4000 && sb.size() != 0; k++) @(posedge clk_sys);
      @(negedge clk_sys);
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s: never observed (cycle %0d)", e.name, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
